// File: rtl/alu_writeback_buffer_pkg.sv
// rtl/alu_writeback_buffer_pkg.sv - shared types and defaults for the ALU writeback buffer
package alu_writeback_buffer_pkg;
  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int ZERO_REG       = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;
endpackage

// File: rtl/alu_writeback_buffer_fifo.sv
// rtl/alu_writeback_buffer_fifo.sv - circular result queue with youngest-match forwarding scan
module alu_writeback_buffer_fifo
  import alu_writeback_buffer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int DEPTH      = 2,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic [REG_ADDR_W-1:0] push_dest,
  input  logic                  pop,
  output logic [DATA_W-1:0]     head_data,
  output logic [REG_ADDR_W-1:0] head_dest,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  input  logic [REG_ADDR_W-1:0] q_addr,
  output logic                  q_hit,
  output logic [DATA_W-1:0]     q_data
);
  logic [DATA_W-1:0]     data_mem [DEPTH];
  logic [REG_ADDR_W-1:0] dest_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_data = data_mem[rd_ptr];
  assign head_dest = dest_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        dest_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        dest_mem[wr_ptr] <= push_dest;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    q_hit  = 1'b0;
    q_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (dest_mem[idx] == q_addr) &&
          (q_addr != REG_ADDR_W'(ZERO_REG))) begin
        q_hit  = 1'b1;
        q_data = data_mem[idx];
      end
    end
  end
endmodule

// File: rtl/alu_writeback_buffer.sv
// rtl/alu_writeback_buffer.sv - queues ALU results and retires them to the register file
module alu_writeback_buffer
  import alu_writeback_buffer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic [DATA_W-1:0]            res_data,
  input  logic [REG_ADDR_W-1:0]        res_dest,
  input  logic                         res_wen,
  input  logic                         flush,
  output logic                         rf_we,
  output logic [REG_ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  input  logic                         rf_ack,
  input  logic [REG_ADDR_W-1:0]        q_addr,
  output logic                         q_hit,
  output logic [DATA_W-1:0]            q_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_state_t             state;
  wb_state_t             state_next;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DATA_W-1:0]     head_data;
  logic [REG_ADDR_W-1:0] head_dest;

  // Ready depends only on stored occupancy, so a full queue stays blocked even when an ack frees a slot.
  assign res_ready = !full;
  assign push      = res_valid && res_ready && res_wen &&
                     (res_dest != REG_ADDR_W'(ZERO_REG));
  assign rf_we     = (state == WRITE);
  assign pop       = rf_we && rf_ack;
  assign rf_waddr  = rf_we ? head_dest : '0;
  assign rf_wdata  = rf_we ? head_data : '0;
  assign busy      = !empty;

  alu_writeback_buffer_fifo #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (res_data),
    .push_dest (res_dest),
    .pop       (pop),
    .head_data (head_data),
    .head_dest (head_dest),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .q_addr    (q_addr),
    .q_hit     (q_hit),
    .q_data    (q_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (push) state_next = WRITE;
      WRITE:   if (rf_ack && (count == CNT_W'(1)) && !push) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end
endmodule

// File: tb/tb_alu_writeback_buffer.sv
// tb/tb_alu_writeback_buffer.sv - directed vectors plus randomized reference-model check
module tb_alu_writeback_buffer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 2;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [DW-1:0] res_data = '0;
  logic [AW-1:0] res_dest = '0;
  logic          res_wen = 1'b0;
  logic          flush = 1'b0;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_ack = 1'b0;
  logic [AW-1:0] q_addr = '0;
  logic          q_hit;
  logic [DW-1:0] q_data;
  logic [CW-1:0] count;
  logic          busy;

  alu_writeback_buffer #(.DATA_W(DW), .REG_ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_dest(res_dest), .res_wen(res_wen), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ack(rf_ack),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input bit hit, input logic [DW-1:0] qd,
                           input bit rdy);
    cmp({tag, ".count"}, 64'(count), 64'(c));
    cmp({tag, ".busy"}, 64'(busy), 64'(c != 0));
    cmp({tag, ".rf_we"}, 64'(rf_we), 64'(we));
    cmp({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(a));
    cmp({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(wd));
    cmp({tag, ".q_hit"}, 64'(q_hit), 64'(hit));
    cmp({tag, ".q_data"}, 64'(q_data), 64'(qd));
    cmp({tag, ".res_ready"}, 64'(res_ready), 64'(rdy));
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [AW-1:0] dst,
                       input bit wen, input bit ack, input bit fl, input logic [AW-1:0] qa);
    res_valid = v; res_data = d; res_dest = dst; res_wen = wen;
    rf_ack = ack; flush = fl; q_addr = qa;
  endtask

  // Reference model: an in-order list of pending register writes.
  typedef struct { logic [AW-1:0] dest; logic [DW-1:0] data; } ent_t;
  ent_t mq[$];

  task automatic model_step();
    bit do_pop;
    bit do_push;
    do_pop  = (mq.size() != 0) && rf_ack;
    do_push = res_valid && (mq.size() < D) && res_wen && (res_dest != 0);
    if (flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{res_dest, res_data});
    end
  endtask

  task automatic model_check(input string tag);
    bit            hit;
    logic [DW-1:0] qd;
    hit = 0; qd = '0;
    foreach (mq[i]) if (q_addr != 0 && mq[i].dest == q_addr) begin hit = 1; qd = mq[i].data; end
    if (mq.size() != 0)
      check_all(tag, mq.size(), 1, mq[0].dest, mq[0].data, hit, qd, mq.size() < D);
    else
      check_all(tag, 0, 0, '0, '0, hit, qd, 1);
  endtask

  task automatic model_cycle(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    model_check(tag);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit v; logic [DW-1:0] d; logic [AW-1:0] dst; bit wen; bit ack; bit fl; logic [AW-1:0] qa;
    int c; bit we; logic [AW-1:0] a; logic [DW-1:0] wd; bit hit; logic [DW-1:0] qd; bit rdy;
  } vec_t;
  vec_t tv[$];

  initial begin
    // single write
    tv.push_back('{1, 32'hAA, 5'd3, 1, 0, 0, 5'd3,  1, 1, 5'd3, 32'hAA, 1, 32'hAA, 1});
    tv.push_back('{0, 32'h0,  5'd0, 0, 1, 0, 5'd3,  0, 0, 5'd0, 32'h0,  0, 32'h0,  1});
    // backpressure
    tv.push_back('{1, 32'h101, 5'd4, 1, 0, 0, 5'd0,  1, 1, 5'd4, 32'h101, 0, 32'h0,   1});
    tv.push_back('{1, 32'h202, 5'd9, 1, 0, 0, 5'd9,  2, 1, 5'd4, 32'h101, 1, 32'h202, 0});
    for (int i = 0; i < 5; i++)
      tv.push_back('{1, 32'h303, 5'd10, 1, 0, 0, 5'd10, 2, 1, 5'd4, 32'h101, 0, 32'h0, 0});
    tv.push_back('{0, 32'h0, 5'd0, 0, 1, 0, 5'd4,  1, 1, 5'd9, 32'h202, 0, 32'h0, 1});
    tv.push_back('{0, 32'h0, 5'd0, 0, 1, 0, 5'd9,  0, 0, 5'd0, 32'h0,   0, 32'h0, 1});
    // filter
    tv.push_back('{1, 32'h55, 5'd0, 1, 0, 0, 5'd0,  0, 0, 5'd0, 32'h0, 0, 32'h0, 1});
    tv.push_back('{1, 32'h66, 5'd5, 0, 0, 0, 5'd5,  0, 0, 5'd0, 32'h0, 0, 32'h0, 1});
    // forwarding
    tv.push_back('{1, 32'h11, 5'd7, 1, 0, 0, 5'd7,  1, 1, 5'd7, 32'h11, 1, 32'h11, 1});
    tv.push_back('{1, 32'h22, 5'd7, 1, 0, 0, 5'd7,  2, 1, 5'd7, 32'h11, 1, 32'h22, 0});
    tv.push_back('{0, 32'h0,  5'd0, 0, 0, 0, 5'd0,  2, 1, 5'd7, 32'h11, 0, 32'h0,  0});
    tv.push_back('{0, 32'h0,  5'd0, 0, 1, 0, 5'd7,  1, 1, 5'd7, 32'h22, 1, 32'h22, 1});
    tv.push_back('{0, 32'h0,  5'd0, 0, 1, 0, 5'd7,  0, 0, 5'd0, 32'h0,  0, 32'h0,  1});

    @(negedge clk);
    check_all("reset", 0, 0, '0, '0, 0, '0, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].v, tv[i].d, tv[i].dst, tv[i].wen, tv[i].ack, tv[i].fl, tv[i].qa);
      cycle();
      check_all($sformatf("vec%0d", i), tv[i].c, tv[i].we, tv[i].a, tv[i].wd,
                tv[i].hit, tv[i].qd, tv[i].rdy);
    end

    // flush overrides push and pop in the same cycle
    drive(1, 32'hA1, 5'd1, 1, 0, 0, 5'd0); cycle();
    drive(1, 32'hA2, 5'd2, 1, 0, 0, 5'd0); cycle();
    cmp("flush.pre_count", 64'(count), 64'd2);
    drive(1, 32'hA3, 5'd3, 1, 1, 1, 5'd3); cycle();
    check_all("flush", 0, 0, '0, '0, 0, '0, 1);
    drive(0, 32'h0, 5'd0, 0, 0, 0, 5'd3); cycle();
    check_all("flush.after", 0, 0, '0, '0, 0, '0, 1);

    // async reset mid-WRITE
    drive(1, 32'hB6, 5'd6, 1, 0, 0, 5'd6); cycle();
    drive(1, 32'hB8, 5'd8, 1, 0, 0, 5'd6); cycle();
    cmp("rst.pre_we", 64'(rf_we), 64'd1);
    drive(0, 32'h0, 5'd0, 0, 0, 0, 5'd6);
    @(posedge clk); #2; rst = 1'b1; #1;
    check_all("async_rst", 0, 0, '0, '0, 0, '0, 1);
    @(negedge clk); rst = 1'b0;
    cycle();
    check_all("post_rst", 0, 0, '0, '0, 0, '0, 1);

    // wrap: push+pop every cycle
    mq.delete();
    drive(1, 32'h1000, 5'd1, 1, 0, 0, 5'd1);
    model_cycle("wrap.first");
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h1000 + 32'(i + 1), 5'(i % 7 + 1), 1, 1, 0, 5'(i % 7 + 1));
      model_cycle($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'h0, 5'd0, 0, 1, 0, 5'd0);
      model_cycle($sformatf("wrap.drain%0d", i));
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)),
            $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0, 5'($urandom_range(0, 7)));
      model_cycle($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
